adc_uart_scheduler: RTL and testbench

Shares one uart_tx byte transmitter between NUM_CH sigma-delta ADC decimator channels. Each channel deposits a sample into a one-deep holding register. A round-robin scheduler serialises pending samples into framed byte sequences on the uart_tx handshake (i_Tx_DV / o_Tx_Active / o_Tx_Done). It sits between the per-channel integrate-and-dump decimators and the single UART pin.

---
 rtl/adc_uart_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_adc_uart_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_uart_scheduler.sv
// adc_uart_scheduler
//
// Shares one uart_tx byte transmitter between NUM_CH ADC decimator channels.
// Each channel has a one-deep holding register. A round-robin scheduler picks
// pending channels and sends each sample as a framed byte sequence over the
// uart_tx handshake. Frame format:
//     SYNC_BYTE, {ovf, 3'b000, ch[3:0]}, NB data bytes (MSB first, zero-extended)
// NB = ceil(DATA_W/8).
//
// Optional build macro:
//     CHECKSUM_EN - appends a trailing byte equal to the XOR of the header and
//                   all data bytes (SYNC excluded). Undefined: no checksum byte
//                   and no XOR logic.
//
// Ports:
//     CLK           system clock
//     rst_n         asynchronous active-low reset
//     sample_valid  per-channel 1-cycle strobe, new sample present
//     sample_data   channel c at bits [c*DATA_W +: DATA_W]
//     tx_dv         1-cycle pulse to uart_tx i_Tx_DV
//     tx_byte       byte to uart_tx i_Tx_Byte, stable from tx_dv until tx_done
//     tx_active     uart_tx o_Tx_Active
//     tx_done       uart_tx o_Tx_Done (1-cycle pulse)
//     overrun       sticky per-channel overrun flags
//     overrun_clr   per-channel clear strobe (a same-cycle set wins)
//     busy          high while a frame is in progress
//     frame_count   frames completed, wraps at 16 bits

module adc_uart_scheduler #(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    output logic                     tx_dv,
    output logic [7:0]               tx_byte,
    input  logic                     tx_active,
    input  logic                     tx_done,
    output logic [NUM_CH-1:0]        overrun,
    input  logic [NUM_CH-1:0]        overrun_clr,
    output logic                     busy,
    output logic [15:0]              frame_count
);

    localparam int NB   = (DATA_W + 7) / 8;
    localparam int FW   = NB * 8;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef CHECKSUM_EN
    localparam int LAST_IDX = NB + 2;
`else
    localparam int LAST_IDX = NB + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q [NUM_CH];
    logic [DATA_W-1:0]   hold_d [NUM_CH];
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          ch_q, ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                busy_q, busy_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic                grant_found;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W-1:0]     cand;
    logic                grant_now;
    logic [7:0]          header;
    logic [7:0]          cur_byte;
`ifdef CHECKSUM_EN
    logic [7:0]          checksum;
`endif

    // Round-robin search: first pending channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // Byte selected by byte_idx: 0 = sync, 1 = header, then data MSB first,
    // then the optional checksum.
    always_comb begin
        header   = {ovf_q, 3'b000, ch_q};
        cur_byte = 8'h00;
        if (byte_idx_q == 3'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_idx_q == 3'd1) begin
            cur_byte = header;
        end
        for (int k = 0; k < NB; k++) begin
            if (int'(byte_idx_q) == k + 2) begin
                cur_byte = frame_q[(NB-1-k)*8 +: 8];
            end
        end
`ifdef CHECKSUM_EN
        checksum = header;
        for (int k = 0; k < NB; k++) begin
            checksum = checksum ^ frame_q[k*8 +: 8];
        end
        if (int'(byte_idx_q) == NB + 2) begin
            cur_byte = checksum;
        end
`endif
    end

    // Next-state logic for the FSM and the capture path. Capture is applied
    // after the grant so that a strobe on the granted channel re-arms pending
    // without flagging overrun, while the frame keeps the old hold value.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q & ~overrun_clr;
        frame_d       = frame_q;
        ovf_d         = ovf_q;
        ch_d          = ch_q;
        rr_ptr_d      = rr_ptr_q;
        byte_idx_d    = byte_idx_q;
        tx_dv_d       = 1'b0;
        tx_byte_d     = tx_byte_q;
        busy_d        = busy_q;
        frame_count_d = frame_count_q;
        grant_now     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant_now                = 1'b1;
                    frame_d                  = '0;
                    frame_d[DATA_W-1:0]      = hold_q[grant_ch];
                    ovf_d                    = overrun_q[grant_ch];
                    ch_d                     = 4'(grant_ch);
                    pending_d[grant_ch]      = 1'b0;
                    if (int'(grant_ch) == NUM_CH - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_ch + 1'b1;
                    end
                    byte_idx_d = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_byte_d = cur_byte;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (!tx_active) begin
                    tx_dv_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (int'(byte_idx_q) == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int c = 0; c < NUM_CH; c++) begin
            if (sample_valid[c]) begin
                hold_d[c] = sample_data[c*DATA_W +: DATA_W];
                if (pending_q[c] && !(grant_now && int'(grant_ch) == c)) begin
                    overrun_d[c] = 1'b1;
                end
                pending_d[c] = 1'b1;
            end
        end
    end

    // State registers; reset asserts immediately and clears everything.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
            end
            pending_q     <= '0;
            overrun_q     <= '0;
            frame_q       <= '0;
            ovf_q         <= 1'b0;
            ch_q          <= 4'd0;
            rr_ptr_q      <= '0;
            byte_idx_q    <= 3'd0;
            tx_dv_q       <= 1'b0;
            tx_byte_q     <= 8'h00;
            busy_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_q       <= frame_d;
            ovf_q         <= ovf_d;
            ch_q          <= ch_d;
            rr_ptr_q      <= rr_ptr_d;
            byte_idx_q    <= byte_idx_d;
            tx_dv_q       <= tx_dv_d;
            tx_byte_q     <= tx_byte_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx_dv       = tx_dv_q;
    assign tx_byte     = tx_byte_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_uart_scheduler.sv
// Testbench for adc_uart_scheduler. Two instances: an 8-bit-sample build
// carrying most of the scenarios and a 12-bit-sample build for the
// two-data-byte frame. Each has a small uart_tx model that records every
// byte presented with tx_dv. Honours CHECKSUM_EN the same way as the design.

module tb_adc_uart_scheduler;

`ifdef CHECKSUM_EN
    localparam int FL   = 4;
    localparam int FL12 = 5;
`else
    localparam int FL   = 3;
    localparam int FL12 = 4;
`endif

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic [7:0] hdr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sample_valid;
    logic [31:0] sample_data;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic [3:0]  overrun;
    logic [3:0]  overrun_clr;
    logic        busy;
    logic [15:0] frame_count;
    logic        model_active;
    logic        stuck_active;

    logic [3:0]  v12;
    logic [47:0] d12;
    logic        dv12;
    logic [7:0]  byte12;
    logic        act12;
    logic        done12;
    logic [3:0]  ovr12;
    logic        busy12;
    logic [15:0] fc12;

    logic [7:0]  rx_q[$];
    logic [7:0]  q12[$];
    int          dv_count;
    int          dv_cycles;
    int          checks;
    int          passes;
    logic [15:0] exp_fc;
    vec_t        vecs[4];

    assign tx_active = model_active | stuck_active;

    adc_uart_scheduler #(.NUM_CH(4), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
        .CLK(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
        .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy), .frame_count(frame_count)
    );

    adc_uart_scheduler #(.NUM_CH(4), .DATA_W(12), .SYNC_BYTE(8'hA5)) dut12 (
        .CLK(clk), .rst_n(rst_n), .sample_valid(v12), .sample_data(d12),
        .tx_dv(dv12), .tx_byte(byte12), .tx_active(act12), .tx_done(done12),
        .overrun(ovr12), .overrun_clr(4'b0000), .busy(busy12), .frame_count(fc12)
    );

    // 100 MHz-style bench clock; absolute rate is irrelevant here.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uart_tx model for the 8-bit build: active for 10 cycles after tx_dv,
    // then a one-cycle done pulse.
    initial begin
        model_active = 1'b0;
        tx_done      = 1'b0;
        dv_count     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_dv === 1'b1) begin
                rx_q.push_back(tx_byte);
                dv_count++;
                model_active = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                model_active = 1'b0;
                tx_done      = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    // Faster uart_tx model for the 12-bit build.
    initial begin
        act12  = 1'b0;
        done12 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dv12 === 1'b1) begin
                q12.push_back(byte12);
                act12 = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                act12  = 1'b0;
                done12 = 1'b1;
                @(posedge clk);
                #1;
                done12 = 1'b0;
            end
        end
    end

    // Counts every cycle tx_dv is high, so a stretched pulse shows up.
    initial begin
        dv_cycles = 0;
        forever begin
            @(posedge clk);
            #3;
            if (tx_dv === 1'b1) dv_cycles++;
        end
    end

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic [3:0] clr);
        @(negedge clk);
        sample_valid = valid;
        sample_data  = data;
        overrun_clr  = clr;
        @(negedge clk);
        sample_valid = 4'b0000;
        overrun_clr  = 4'b0000;
    endtask

    task automatic waitFrames(input string name, input int nbytes);
        int n;
        n = 0;
        while ((rx_q.size() < nbytes || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " byte count"}, 16'(rx_q.size()), 16'(nbytes));
    endtask

    task automatic popByte(output logic [15:0] b);
        if (rx_q.size() > 0) b = {8'h00, rx_q.pop_front()};
        else b = 16'hFFFF;
    endtask

    task automatic checkFrame(input string name, input logic [7:0] hdr, input logic [7:0] dat);
        logic [15:0] b;
        popByte(b);
        checkOutput({name, " sync"}, b, 16'h00A5);
        popByte(b);
        checkOutput({name, " header"}, b, {8'h00, hdr});
        popByte(b);
        checkOutput({name, " data"}, b, {8'h00, dat});
`ifdef CHECKSUM_EN
        popByte(b);
        checkOutput({name, " checksum"}, b, {8'h00, hdr ^ dat});
`endif
    endtask

    initial begin
        logic [7:0]  exp12[5];
        logic [15:0] b;
        int          n;
        int          base;
        int          lat;
        logic        found;

        checks = 0;
        passes = 0;
        exp_fc = 16'd0;
        vecs[0] = '{2'd1, 8'h3C, 8'h01};
        vecs[1] = '{2'd0, 8'h5A, 8'h00};
        vecs[2] = '{2'd3, 8'hFF, 8'h03};
        vecs[3] = '{2'd2, 8'h00, 8'h02};

        rst_n        = 1'b0;
        sample_valid = 4'b0000;
        sample_data  = 32'h0;
        overrun_clr  = 4'b0000;
        stuck_active = 1'b0;
        v12          = 4'b0000;
        d12          = 48'h0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset tx_dv", {15'd0, tx_dv}, 16'd0);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset tx_byte", {8'd0, tx_byte}, 16'd0);
        checkOutput("reset overrun", {12'd0, overrun}, 16'd0);
        checkOutput("reset frame_count", frame_count, 16'd0);
        rst_n = 1'b1;

        // Round robin from pointer 0: ch0, ch2, ch3, then ch0 before ch3
        applyStimulus(4'b1101, 32'h3322_0011, 4'b0000);
        waitFrames("rr three", 3 * FL);
        checkFrame("rr ch0", 8'h00, 8'h11);
        checkFrame("rr ch2", 8'h02, 8'h22);
        checkFrame("rr ch3", 8'h03, 8'h33);
        exp_fc = exp_fc + 16'd3;
        checkOutput("rr frame_count", frame_count, exp_fc);
        applyStimulus(4'b1001, 32'h4400_0055, 4'b0000);
        waitFrames("rr two", 2 * FL);
        checkFrame("rr2 ch0", 8'h00, 8'h55);
        checkFrame("rr2 ch3", 8'h03, 8'h44);
        exp_fc = exp_fc + 16'd2;

        // 12-bit samples: two data bytes, upper nibble zero-extended
        @(negedge clk);
        v12 = 4'b1000;
        d12 = 48'hABC << 36;
        @(negedge clk);
        v12 = 4'b0000;
        n = 0;
        while ((q12.size() < FL12 || busy12) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("w12 byte count", 16'(q12.size()), 16'(FL12));
        exp12[0] = 8'hA5;
        exp12[1] = 8'h03;
        exp12[2] = 8'h0A;
        exp12[3] = 8'hBC;
        exp12[4] = 8'hB5;
        for (int i = 0; i < FL12; i++) begin
            if (q12.size() > 0) b = {8'h00, q12.pop_front()};
            else b = 16'hFFFF;
            checkOutput($sformatf("w12 byte %0d", i), b, {8'h00, exp12[i]});
        end
        checkOutput("w12 frame_count", fc12, 16'd1);

        // Single-channel frames from the table
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001 << vecs[i].ch, 32'(vecs[i].data) << (8 * vecs[i].ch), 4'b0000);
            waitFrames($sformatf("vec%0d", i), FL);
            checkFrame($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].data);
            exp_fc = exp_fc + 16'd1;
            checkOutput($sformatf("vec%0d frame_count", i), frame_count, exp_fc);
            checkOutput($sformatf("vec%0d busy", i), {15'd0, busy}, 16'd0);
        end

        // Overrun while a frame is in flight; set wins over a same-cycle clear
        applyStimulus(4'b0001, 32'h0000_0066, 4'b0000);
        applyStimulus(4'b0110, 32'h0010_7700, 4'b0000);
        applyStimulus(4'b0110, 32'h0020_7800, 4'b0010);
        checkOutput("overrun set", {12'd0, overrun}, 16'h0006);
        waitFrames("overrun", 3 * FL);
        checkFrame("ovr ch0", 8'h00, 8'h66);
        checkFrame("ovr ch1", 8'h81, 8'h78);
        checkFrame("ovr ch2", 8'h82, 8'h20);
        exp_fc = exp_fc + 16'd3;
        checkOutput("overrun sticky", {12'd0, overrun}, 16'h0006);
        applyStimulus(4'b0000, 32'h0, 4'b0100);
        checkOutput("overrun clr ch2", {12'd0, overrun}, 16'h0002);
        applyStimulus(4'b0000, 32'h0, 4'b0010);
        checkOutput("overrun clr ch1", {12'd0, overrun}, 16'h0000);

        // Strobe on the channel in its grant cycle: old value sent, new pending
        @(negedge clk);
        sample_valid = 4'b1000;
        sample_data  = 32'hAA00_0000;
        @(negedge clk);
        sample_data  = 32'hBB00_0000;
        @(negedge clk);
        sample_valid = 4'b0000;
        checkOutput("collision overrun", {12'd0, overrun}, 16'h0000);
        waitFrames("collision", 2 * FL);
        checkFrame("collision old", 8'h03, 8'hAA);
        checkFrame("collision new", 8'h03, 8'hBB);
        exp_fc = exp_fc + 16'd2;

        // tx_active held high: no tx_dv until it drops, then a single pulse
        @(negedge clk);
        stuck_active = 1'b1;
        base = dv_cycles;
        applyStimulus(4'b0100, 32'h00E7_0000, 4'b0000);
        repeat (50) @(negedge clk);
        checkOutput("stuck no dv", 16'(dv_cycles), 16'(base));
        checkOutput("stuck busy", {15'd0, busy}, 16'd1);
        stuck_active = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("release one dv", 16'(dv_cycles), 16'(base + 1));
        waitFrames("stuck", FL);
        checkFrame("stuck ch2", 8'h02, 8'hE7);
        exp_fc = exp_fc + 16'd1;
        checkOutput("stuck frame_count", frame_count, exp_fc);

        // frame_count wrap
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        exp_fc = 16'hFFFF;
        checkOutput("wrap preset", frame_count, exp_fc);
        applyStimulus(4'b0010, 32'h0000_9900, 4'b0000);
        waitFrames("wrap", FL);
        checkFrame("wrap ch1", 8'h01, 8'h99);
        exp_fc = exp_fc + 16'd1;
        checkOutput("wrap frame_count", frame_count, exp_fc);

        // Reset mid-frame after the second byte's tx_dv
        base = dv_count;
        applyStimulus(4'b0001, 32'h0000_00C1, 4'b0000);
        applyStimulus(4'b1000, 32'hAA00_0000, 4'b0000);
        applyStimulus(4'b1000, 32'hBB00_0000, 4'b0000);
        checkOutput("pre-reset overrun", {12'd0, overrun}, 16'h0008);
        n = 0;
        while (dv_count < base + 2 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("pre-reset second dv", {15'd0, tx_dv}, 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tx_dv", {15'd0, tx_dv}, 16'd0);
        checkOutput("async reset busy", {15'd0, busy}, 16'd0);
        checkOutput("async reset overrun", {12'd0, overrun}, 16'd0);
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        exp_fc = 16'd0;

        // Clean frame after reset, with capture-to-tx_dv latency
        applyStimulus(4'b0001, 32'h0000_005C, 4'b0000);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
            if (tx_dv === 1'b1) found = 1'b1;
        end
        checkOutput("latency", 16'(lat), 16'd3);
        waitFrames("post-reset", FL);
        checkFrame("post-reset ch0", 8'h00, 8'h5C);
        exp_fc = exp_fc + 16'd1;
        repeat (100) @(negedge clk);
        checkOutput("no stale frame", 16'(rx_q.size()), 16'd0);
        checkOutput("post-reset frame_count", frame_count, exp_fc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
